multicycle_control_fsm: RTL and testbench

- Multi-cycle sequencer for the RV32I core. Replaces the single-cycle decode with a FETCH/DECODE/EXEC/MEM/WB state machine.
- Drives the shared datapath (ALU, register file, unified instruction/data memory port) one phase per cycle.
- Waits on a memory ready handshake and traps on illegal opcodes or memory timeout.
- Supports R-type, OP-IMM, LOAD, STORE, BRANCH, LUI and JAL.

---
 rtl/multicycle_control_fsm.sv | 271 +++++++++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control sequencer for the RV32I core.
// Steps the shared datapath through FETCH/DECODE/EXEC/MEM/WB, one phase per
// cycle. It waits on the memory ready handshake, traps on unsupported opcodes
// or on a memory access that never completes, and counts retired instructions.
module multicycle_control_fsm #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             RegWrite,
  output logic             ALUSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUOp,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IorD,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic [1:0]       PCSrc,
  output logic             Branch,
  output logic [1:0]       wb_sel,
  output logic [2:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  // Wait counter only has to count up to MEM_TIMEOUT-1 before the trap fires.
  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // ALU operand A selects
  localparam logic [1:0] A_RS1  = 2'b00;
  localparam logic [1:0] A_PC   = 2'b01;
  localparam logic [1:0] A_ZERO = 2'b10;

  // ALU operation selects
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // PC source selects
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_TARGET = 2'b01;

  // Write-back data selects
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MDR = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;

  state_t             state_q, state_d;
  logic [6:0]         op_q, op_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   instret_q, instret_d;
  logic               illegal_q, illegal_d;
  logic               retire;
  logic               wait_expired;
  logic               op_supported;

  // Opcode whitelist checked while the instruction is being decoded.
  always_comb begin
    op_supported = 1'b0;
    case (opcode)
      OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_JAL: op_supported = 1'b1;
      default: op_supported = 1'b0;
    endcase
  end

  // Another idle memory cycle at this count would exhaust the allowed wait.
  always_comb begin
    wait_expired = 1'b0;
    if (MEM_TIMEOUT > 0) begin
      wait_expired = (wait_q == WAIT_W'(MEM_TIMEOUT - 1));
    end
  end

  // Next-state, opcode latch, wait counter and retire pulse.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    wait_d  = '0;
    retire  = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (wait_expired) begin
          state_d = S_TRAP;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        op_d    = opcode;
        state_d = op_supported ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        case (op_q)
          OP_R, OP_IMM, OP_LUI: state_d = S_WB;
          OP_LOAD, OP_STORE:    state_d = S_MEM;
          OP_BRANCH, OP_JAL: begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
          default: state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          if (op_q == OP_LOAD) begin
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        end else if (wait_expired) begin
          state_d = S_TRAP;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_TRAP;
      end
    endcase
    instret_d = instret_q + (retire ? CNT_W'(1) : CNT_W'(0));
    illegal_d = illegal_q | (state_d == S_TRAP);
  end

  // Datapath control decode; everything is forced low while reset is held so
  // an aborted access cannot complete a write.
  always_comb begin
    RegWrite = 1'b0;
    ALUSrc   = 1'b0;
    ALUSrcA  = A_RS1;
    ALUOp    = ALU_ADD;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IorD     = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    PCSrc    = PC_ALU;
    Branch   = 1'b0;
    wb_sel   = WB_ALU;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          // ALU forms PC+4 while the instruction is read from PC.
          MemRead = 1'b1;
          IorD    = 1'b0;
          ALUSrcA = A_PC;
          ALUSrc  = 1'b1;
          ALUOp   = ALU_ADD;
          if (mem_ready) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            PCSrc   = PC_ALU;
          end
        end
        S_DECODE: begin
          // Speculative branch/jump target PC+imm into the target register.
          ALUSrcA = A_PC;
          ALUSrc  = 1'b1;
          ALUOp   = ALU_ADD;
        end
        S_EXEC: begin
          case (op_q)
            OP_R: begin
              ALUSrcA = A_RS1;
              ALUSrc  = 1'b0;
              ALUOp   = ALU_FUNCT;
            end
            OP_IMM: begin
              ALUSrcA = A_RS1;
              ALUSrc  = 1'b1;
              ALUOp   = ALU_FUNCT;
            end
            OP_LOAD, OP_STORE: begin
              ALUSrcA = A_RS1;
              ALUSrc  = 1'b1;
              ALUOp   = ALU_ADD;
            end
            OP_BRANCH: begin
              ALUSrcA = A_RS1;
              ALUSrc  = 1'b0;
              ALUOp   = ALU_SUB;
              Branch  = 1'b1;
              PCSrc   = PC_TARGET;
              PCWrite = zero;
            end
            OP_LUI: begin
              ALUSrcA = A_ZERO;
              ALUSrc  = 1'b1;
              ALUOp   = ALU_ADD;
            end
            OP_JAL: begin
              // Link register gets the already-incremented PC.
              RegWrite = 1'b1;
              wb_sel   = WB_PC;
              PCWrite  = 1'b1;
              PCSrc    = PC_TARGET;
            end
            default: begin
              RegWrite = 1'b0;
            end
          endcase
        end
        S_MEM: begin
          IorD     = 1'b1;
          MemRead  = (op_q == OP_LOAD);
          MemWrite = (op_q == OP_STORE);
        end
        S_WB: begin
          RegWrite = 1'b1;
          wb_sel   = (op_q == OP_LOAD) ? WB_MDR : WB_ALU;
        end
        default: begin
          RegWrite = 1'b0;
        end
      endcase
    end
  end

  // Sequencer state, latched opcode, wait counter, retire count, trap flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      wait_q    <= '0;
      instret_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: directed scenarios followed
// by random instruction streams, compared cycle by cycle against a phase-level
// model of each instruction's life.
module tb_multicycle_control_fsm;

  localparam int MT = 4;
  localparam int CW = 4;

  localparam logic [6:0] R_T  = 7'b0110011;
  localparam logic [6:0] IMM  = 7'b0010011;
  localparam logic [6:0] LD   = 7'b0000011;
  localparam logic [6:0] ST   = 7'b0100011;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] LUI  = 7'b0110111;
  localparam logic [6:0] JAL  = 7'b1101111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [6:0] opcode = '0;
  logic zero = 1'b0;
  logic mem_ready = 1'b0;
  logic RegWrite, ALUSrc, MemRead, MemWrite, IorD, IRWrite, PCWrite, Branch, illegal;
  logic [1:0] ALUSrcA, ALUOp, PCSrc, wb_sel;
  logic [2:0] state;
  logic [CW-1:0] instret;

  int tests = 0;
  int fails = 0;
  int model_ret = 0;
  bit trapped = 1'b0;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.CNT_W(CW), .MEM_TIMEOUT(MT)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .RegWrite(RegWrite), .ALUSrc(ALUSrc), .ALUSrcA(ALUSrcA), .ALUOp(ALUOp),
    .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .Branch(Branch), .wb_sel(wb_sel),
    .state(state), .illegal(illegal), .instret(instret)
  );

  wire [31:0] obs = {8'h00, instret, state, RegWrite, ALUSrc, ALUSrcA, ALUOp, MemRead,
                     MemWrite, IorD, IRWrite, PCWrite, PCSrc, Branch, wb_sel, illegal};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Pack an expected cycle in the same order as obs, using the model's count.
  function automatic logic [31:0] mk(input logic [2:0] st, input logic rw, input logic asrc,
                                     input logic [1:0] asrca, input logic [1:0] aop,
                                     input logic mr, input logic mw, input logic iord,
                                     input logic irw, input logic pcw, input logic [1:0] pcsrc,
                                     input logic br, input logic [1:0] wb, input logic ill);
    logic [CW-1:0] ir;
    ir = CW'(model_ret % (1 << CW));
    return {8'h00, ir, st, rw, asrc, asrca, aop, mr, mw, iord, irw, pcw, pcsrc, br, wb, ill};
  endfunction

  function automatic bit supported(input logic [6:0] op);
    return (op == R_T) || (op == IMM) || (op == LD) || (op == ST) ||
           (op == BR) || (op == LUI) || (op == JAL);
  endfunction

  function automatic logic [31:0] ev_fetch(input logic done);
    return mk(3'd0, 0, 1, 2'b01, 2'b00, 1, 0, 0, done, done, 2'b00, 0, 2'b00, 0);
  endfunction

  function automatic logic [31:0] ev_decode();
    return mk(3'd1, 0, 1, 2'b01, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0);
  endfunction

  function automatic logic [31:0] ev_exec(input logic [6:0] op, input logic z);
    case (op)
      R_T:     return mk(3'd2, 0, 0, 2'b00, 2'b10, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0);
      IMM:     return mk(3'd2, 0, 1, 2'b00, 2'b10, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0);
      BR:      return mk(3'd2, 0, 0, 2'b00, 2'b01, 0, 0, 0, 0, z, 2'b01, 1, 2'b00, 0);
      LUI:     return mk(3'd2, 0, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0);
      JAL:     return mk(3'd2, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 2'b01, 0, 2'b10, 0);
      default: return mk(3'd2, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0);
    endcase
  endfunction

  function automatic logic [31:0] ev_mem(input logic ld);
    return mk(3'd3, 0, 0, 2'b00, 2'b00, ld, !ld, 1, 0, 0, 2'b00, 0, 2'b00, 0);
  endfunction

  function automatic logic [31:0] ev_wb(input logic ld);
    return mk(3'd4, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, ld ? 2'b01 : 2'b00, 0);
  endfunction

  function automatic logic [31:0] ev_trap();
    return mk(3'd7, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1);
  endfunction

  // One clock: drive mem_ready, check outputs mid-cycle, advance past the edge.
  task automatic step(input logic rdy, input logic [31:0] e, input string tag);
    mem_ready = rdy;
    @(negedge clk);
    check(tag, obs, e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_assert", obs, 32'h0);
    @(posedge clk);
    #1;
    check("rst_hold", obs, 32'h0);
    rst = 1'b0;
    model_ret = 0;
    trapped = 1'b0;
  endtask

  task automatic trap_hold(input int n);
    for (int k = 0; k < n; k++) step(1'($urandom % 2), ev_trap(), "trap_hold");
  endtask

  // Run one instruction through all of its phases against the model.
  // fwait/mwait: idle memory cycles before ready; abort: reset in first MEM cycle.
  task automatic run_instr(input logic [6:0] op, input logic z, input int fwait,
                           input int mwait, input bit abort, input string name);
    logic ld;
    ld = (op == LD);
    zero = z;
    opcode = 7'($urandom);
    for (int i = 0; i <= fwait; i++) begin
      if (i == fwait) begin
        step(1'b1, ev_fetch(1'b1), {name, "/fetch"});
      end else begin
        step(1'b0, ev_fetch(1'b0), {name, "/fetch_wait"});
        if (i + 1 == MT) begin
          trapped = 1'b1;
          return;
        end
      end
    end
    opcode = op;
    step(1'($urandom % 2), ev_decode(), {name, "/decode"});
    if (!supported(op)) begin
      trapped = 1'b1;
      return;
    end
    step(1'($urandom % 2), ev_exec(op, z), {name, "/exec"});
    if (op == BR || op == JAL) begin
      model_ret++;
      return;
    end
    if (op == LD || op == ST) begin
      if (abort) begin
        mem_ready = 1'b0;
        @(negedge clk);
        check({name, "/mem"}, obs, ev_mem(ld));
        #2;
        rst = 1'b1;
        #1;
        check({name, "/abort"}, obs, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_ret = 0;
        trapped = 1'b0;
        return;
      end
      for (int i = 0; i <= mwait; i++) begin
        if (i == mwait) begin
          step(1'b1, ev_mem(ld), {name, "/mem"});
        end else begin
          step(1'b0, ev_mem(ld), {name, "/mem_wait"});
          if (i + 1 == MT) begin
            trapped = 1'b1;
            return;
          end
        end
      end
      if (!ld) begin
        model_ret++;
        return;
      end
    end
    step(1'($urandom % 2), ev_wb(ld), {name, "/wb"});
    model_ret++;
  endtask

  task automatic do_instr(input logic [6:0] op, input logic z, input int fwait,
                          input int mwait, input string name);
    run_instr(op, z, fwait, mwait, 1'b0, name);
    if (trapped) begin
      trap_hold(3);
      do_reset();
    end
  endtask

  logic [6:0] op_tab [0:8];

  initial begin
    op_tab[0] = R_T; op_tab[1] = IMM; op_tab[2] = LD; op_tab[3] = ST; op_tab[4] = BR;
    op_tab[5] = LUI; op_tab[6] = JAL; op_tab[7] = 7'b0000000; op_tab[8] = 7'b1110011;

    #2;
    check("reset_state", obs, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    do_instr(IMM, 1'b0, 0, 0, "addi");
    do_instr(LD,  1'b0, 0, 3, "lw");
    do_instr(BR,  1'b1, 0, 0, "beq_taken");
    do_instr(BR,  1'b0, 0, 0, "beq_not");
    do_instr(ST,  1'b0, 0, 0, "sw");
    do_instr(JAL, 1'b0, 0, 0, "jal");
    do_instr(R_T, 1'b0, 1, 0, "add");
    do_instr(LUI, 1'b0, 2, 0, "lui");

    run_instr(7'b0000000, 1'b0, 0, 0, 1'b0, "illegal");
    trap_hold(20);
    do_reset();

    do_instr(IMM, 1'b0, MT, 0, "fetch_timeout");
    do_instr(IMM, 1'b0, MT - 1, 0, "fetch_edge");
    do_instr(LD,  1'b0, 0, MT, "mem_timeout");
    do_instr(ST,  1'b0, 0, MT - 1, "mem_edge");

    run_instr(ST, 1'b0, 0, 2, 1'b1, "sw_abort");

    // Enough back-to-back retirements to wrap the counter.
    for (int n = 0; n < (1 << CW) + 2; n++) do_instr(IMM, 1'b0, 0, 0, "wrap");

    for (int n = 0; n < 400; n++) begin
      int sel;
      int fw;
      int mw;
      sel = ($urandom % 16 == 0) ? 7 + int'($urandom % 2) : int'($urandom % 7);
      fw = ($urandom % 10 == 0) ? MT : int'($urandom % MT);
      mw = ($urandom % 10 == 0) ? MT + 1 : int'($urandom % MT);
      do_instr(op_tab[sel], 1'($urandom % 2), fw, mw, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
